song_reader: RTL
================

# song_reader

Sequencer that walks the 16-bit song ROM word stream for the selected song and dispatches notes to a bank of note players. It issues ROM addresses, decodes each word, hands non-advance entries out immediately as chord voices, and holds on advance entries for their duration in beats. It sits between the song ROM and the note players, under control of the top-level play/song-select logic.

## Interface

**Parameters**
- `NUM_VOICES`, 3, number of note players; round-robin voice allocation (2–4 supported).
- `SONG_W`, 2, song-select width; forms the upper ROM address bits.
- `IDX_W`, 5, entry-index width; entries per song are 2^IDX_W.

**Ports**
- `clk`  in  1  system clock.
- `reset`  in  1  reset; one clock domain, synchronous, active-high.
- `play`  in  1  level; 1 = run, 0 = pause.
- `song`  in  SONG_W  song select.
- `beat`  in  1  single-cycle beat tick from the beat generator.
- `addr`  out  SONG_W+IDX_W  registered ROM address, `{song_latched, index}`.
- `dout`  in  16  ROM word `{advance, note[5:0], duration[5:0], meta[2:0]}`; valid one cycle after `addr`.
- `note_load`  out  NUM_VOICES  one-hot, single-cycle load strobe to a voice.
- `note_out`  out  6  note for the strobed voice.
- `dur_out`  out  6  duration for the strobed voice.
- `meta_out`  out  3  meta bits for the strobed voice.
- `song_done`  out  1  single-cycle pulse when the last entry of the song completes.

## Operation

**States:** IDLE, FETCH, ROMWAIT, DISPATCH, HOLD, DONE.

- **IDLE**
  - `index` = 0, `voice_ptr` = 0.
  - `play` = 1 → latch `song` into `song_latched`, go to FETCH.
- **FETCH**
  - Register `addr` = `{song_latched, index}`, go to ROMWAIT.
- **ROMWAIT**
  - Wait one cycle for ROM latency, go to DISPATCH.
- **DISPATCH** (decodes `dout`)
  - `note` ≠ 0: pulse `note_load[voice_ptr]` for one cycle, drive `note_out`/`dur_out`/`meta_out` from the word, then `voice_ptr` = (`voice_ptr`+1) mod NUM_VOICES.
  - `note` = 0 (rest): no strobe.
  - `advance` = 0: `index`+1, go to FETCH (chord member, no time elapses).
  - `advance` = 1, `duration` = 0: treated as zero wait; same next-entry handling as the end of HOLD.
  - `advance` = 1, `duration` > 0: load `wait_cnt` = `duration`, go to HOLD.
- **HOLD**
  - On each `beat` with `play` = 1, decrement `wait_cnt`.
  - When it reaches 0: `voice_ptr` = 0, go to the next entry.
- **Next entry**
  - If `index` ≠ max: `index`+1, go to FETCH.
  - If `index` = max: pulse `song_done`, go to DONE.
- **DONE**
  - Outputs idle.
  - `play` = 0 → IDLE.

**Pause and song change**
- `play` = 0 in FETCH/ROMWAIT/DISPATCH/HOLD freezes the FSM, counters and `addr`.
- Beats during pause are ignored and strobes are suppressed; DISPATCH re-evaluates on resume.
- `song` ≠ `song_latched` while not in IDLE/DONE: abort, `index` = 0, `voice_ptr` = 0, relatch, go to FETCH next cycle. This takes priority over all transitions.

**Chords**
- More than NUM_VOICES notes in one chord wrap `voice_ptr` and reload voice 0.

**Widths**
- `wait_cnt` is 6 bits and never underflows.
- `index` wraps modulo 2^IDX_W only under the loop option.

## Timing

- Reset values:
  - `addr` = 0, `note_load` = 0, `note_out` = 0, `dur_out` = 0, `meta_out` = 0, `song_done` = 0.
  - State = IDLE, `index` = 0, `voice_ptr` = 0, `wait_cnt` = 0.
- Reset mid-song returns to IDLE next cycle with no strobe.
- `play` rise in IDLE (cycle 0) → FETCH in cycle 1, `addr` valid in cycle 2, `note_load` in cycle 3.
- Chord entries consume 3 cycles each.
- HOLD: the entry after an advance word of duration D is fetched the cycle after the D-th counted beat.
  - A `beat` that arrives in the same cycle as DISPATCH is not counted.
- `song_done` is coincident with the final transition and lasts exactly one cycle.
- `note_out`/`dur_out`/`meta_out` hold their values until the next strobe.

## Configuration

- `SONG_READER_LOOP_EN` defined:
  - At the last entry, pulse `song_done`, then `index` = 0 and go to FETCH. The song repeats until `play` = 0 or the song changes.
  - DONE is unreachable.
- Not defined: stop in DONE as described in Operation.

## Test plan

- **Chord then advance.** Bench ROM index0 = {0,49,12,7}, index1 = {1,1,12,7}; `play` = 1.
  - `note_load` = 001 with note 49/dur 12, then 3 cycles later `note_load` = 010 with note 1.
  - `addr` = 2 appears only after the 12th `beat`.
- **Rest.** Entry {1,0,4,7}.
  - No `note_load`; 4 beats, then the next fetch; `voice_ptr` back to 0.
- **Pause.** Deassert `play` during HOLD after 5 of 12 beats; pulse `beat` 10 times; reassert.
  - 7 more beats are needed before the next fetch.
- **Song change.** `song` 0→2 mid-HOLD.
  - Next cycle FETCH with `addr` = 64, `index` = 0, no `song_done`.
- **End of song.** Song of 32 entries each {1,0,0,0}.
  - `song_done` pulses once after index 31; without the macro, state DONE until `play` = 0.
  - With `SONG_READER_LOOP_EN`, the next `addr` = `{song,0}`.
- **Reset** asserted mid-DISPATCH.
  - No strobe, all outputs 0 next cycle.

Source files
------------

// File: rtl/song_reader.sv
// Song ROM sequencer: fetches {advance, note, duration, meta} words and hands notes
// to round-robin voices. Optional `SONG_READER_LOOP_EN repeats the song instead of stopping.
module song_reader #(
    parameter int NUM_VOICES = 3,
    parameter int SONG_W     = 2,
    parameter int IDX_W      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    input  logic                    beat,
    output logic [SONG_W+IDX_W-1:0] addr,
    input  logic [15:0]             dout,
    output logic [NUM_VOICES-1:0]   note_load,
    output logic [5:0]              note_out,
    output logic [5:0]              dur_out,
    output logic [2:0]              meta_out,
    output logic                    song_done
);

    localparam int VP_W = $clog2(NUM_VOICES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ROMWAIT,
        S_DISPATCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          index_q, index_d;
    logic [VP_W-1:0]           voice_ptr_q, voice_ptr_d;
    logic [5:0]                wait_cnt_q, wait_cnt_d;
    logic [SONG_W-1:0]         song_latched_q, song_latched_d;
    logic [SONG_W+IDX_W-1:0]   addr_q, addr_d;
    logic [5:0]                note_q, note_d;
    logic [5:0]                dur_q, dur_d;
    logic [2:0]                meta_q, meta_d;

    logic                      w_adv;
    logic [5:0]                w_note;
    logic [5:0]                w_dur;
    logic [2:0]                w_meta;

    logic                      song_change;
    logic                      last_entry;
    logic                      entry_end;
    logic                      dispatch_strobe;
    logic                      final_step;
    logic                      note_strobe;

    assign w_adv  = dout[15];
    assign w_note = dout[14:9];
    assign w_dur  = dout[8:3];
    assign w_meta = dout[2:0];

    assign song_change = (state_q != S_IDLE) && (state_q != S_DONE) && (song != song_latched_q);
    assign last_entry  = (index_q == {IDX_W{1'b1}});

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            index_q        <= '0;
            voice_ptr_q    <= '0;
            wait_cnt_q     <= '0;
            song_latched_q <= '0;
            addr_q         <= '0;
            note_q         <= '0;
            dur_q          <= '0;
            meta_q         <= '0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            voice_ptr_q    <= voice_ptr_d;
            wait_cnt_q     <= wait_cnt_d;
            song_latched_q <= song_latched_d;
            addr_q         <= addr_d;
            note_q         <= note_d;
            dur_q          <= dur_d;
            meta_q         <= meta_d;
        end
    end

    // Next-state logic; a song change overrides everything, including pause.
    always_comb begin
        state_d         = state_q;
        index_d         = index_q;
        voice_ptr_d     = voice_ptr_q;
        wait_cnt_d      = wait_cnt_q;
        song_latched_d  = song_latched_q;
        addr_d          = addr_q;
        note_d          = note_q;
        dur_d           = dur_q;
        meta_d          = meta_q;
        entry_end       = 1'b0;
        dispatch_strobe = 1'b0;
        final_step      = 1'b0;

        if (song_change) begin
            state_d        = S_FETCH;
            index_d        = '0;
            voice_ptr_d    = '0;
            wait_cnt_d     = '0;
            song_latched_d = song;
            addr_d         = {song, {IDX_W{1'b0}}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    index_d     = '0;
                    voice_ptr_d = '0;
                    if (play) begin
                        song_latched_d = song;
                        state_d        = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (play) begin
                        addr_d  = {song_latched_q, index_q};
                        state_d = S_ROMWAIT;
                    end
                end
                S_ROMWAIT: begin
                    if (play) begin
                        state_d = S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (play) begin
                        if (w_note != 6'd0) begin
                            dispatch_strobe = 1'b1;
                            note_d          = w_note;
                            dur_d           = w_dur;
                            meta_d          = w_meta;
                            voice_ptr_d     = (voice_ptr_q == VP_W'(NUM_VOICES - 1)) ?
                                              '0 : voice_ptr_q + VP_W'(1);
                        end
                        if (!w_adv) begin
                            // A chord member on the last entry still ends the song.
                            if (last_entry) begin
                                entry_end = 1'b1;
                            end else begin
                                index_d = index_q + IDX_W'(1);
                                state_d = S_FETCH;
                            end
                        end else if (w_dur == 6'd0) begin
                            entry_end = 1'b1;
                        end else begin
                            wait_cnt_d = w_dur;
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (play && beat) begin
                        if (wait_cnt_q <= 6'd1) begin
                            wait_cnt_d = '0;
                            entry_end  = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q - 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!play) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (entry_end) begin
                voice_ptr_d = '0;
                if (!last_entry) begin
                    index_d = index_q + IDX_W'(1);
                    state_d = S_FETCH;
                end else begin
                    final_step = 1'b1;
`ifdef SONG_READER_LOOP_EN
                    index_d = '0;
                    state_d = S_FETCH;
`else
                    state_d = S_DONE;
`endif
                end
            end
        end
    end

    // Outputs: strobes are combinational with the decode so they land in the DISPATCH cycle.
    always_comb begin
        note_strobe = dispatch_strobe && !reset;
        song_done   = final_step && !reset;
        addr        = addr_q;
        note_out    = note_strobe ? w_note : note_q;
        dur_out     = note_strobe ? w_dur  : dur_q;
        meta_out    = note_strobe ? w_meta : meta_q;
    end

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_load
            assign note_load[gi] = note_strobe && (voice_ptr_q == VP_W'(gi));
        end
    endgenerate

endmodule
